// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle control FSM.
// TRAP state exists only when MC_ILLEGAL_TRAP_EN is defined.
package mc_pkg;

  typedef enum logic [3:0] {
    ST_RESET,
    ST_FETCH,
    ST_DECODE,
    ST_MEM_ADDR,
    ST_MEM_READ,
    ST_MEM_WB,
    ST_MEM_WRITE,
    ST_EXEC_R,
    ST_ALU_WB,
    ST_BRANCH
`ifdef MC_ILLEGAL_TRAP_EN
    , ST_TRAP
`endif
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_REG   = 2'b10;

  localparam logic [1:0] SRC_B_REG  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

endpackage

// File: rtl/mc_retire_counter.sv
// Wrapping retired-instruction counter with increment enable.
// Async active-low reset clears the count.
module mc_retire_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (inc)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle RV32I subset core.
// Define MC_ILLEGAL_TRAP_EN to trap on unknown opcodes.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             pc_source,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             retired,
  output logic [CNT_W-1:0] instr_count,
  output logic             illegal_insn
);

  state_t state, state_nx;
  logic   rel_q;

  // RESET is held one extra cycle after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RESET;
      rel_q <= 1'b0;
    end else begin
      state <= state_nx;
      rel_q <= 1'b1;
    end
  end

  always_comb begin
    state_nx      = state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    pc_source     = 1'b0;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_REG;
    alu_op        = ALUOP_ADD;
    retired       = 1'b0;
    illegal_insn  = 1'b0;
    unique case (state)
      ST_RESET: begin
        if (rel_q)
          state_nx = ST_FETCH;
      end
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_FOUR;
        alu_op    = ALUOP_ADD;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_nx = ST_DECODE;
        end
      end
      ST_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        unique case (1'b1)
          (opcode == OP_LOAD),
          (opcode == OP_STORE):  state_nx = ST_MEM_ADDR;
          (opcode == OP_RTYPE):  state_nx = ST_EXEC_R;
          (opcode == OP_BRANCH): state_nx = ST_BRANCH;
`ifdef MC_ILLEGAL_TRAP_EN
          default:               state_nx = ST_TRAP;
`else
          default:               state_nx = ST_FETCH;
`endif
        endcase
      end
      ST_MEM_ADDR: begin
        alu_src_a = SRC_A_REG;
        alu_src_b = SRC_B_IMM;
        state_nx  = (opcode == OP_STORE) ? ST_MEM_WRITE
                                         : ST_MEM_READ;
      end
      ST_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready)
          state_nx = ST_MEM_WB;
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retired    = 1'b1;
        state_nx   = ST_FETCH;
      end
      ST_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          retired  = 1'b1;
          state_nx = ST_FETCH;
        end
      end
      ST_EXEC_R: begin
        alu_src_a = SRC_A_REG;
        alu_src_b = SRC_B_REG;
        alu_op    = ALUOP_FUNCT;
        state_nx  = ST_ALU_WB;
      end
      ST_ALU_WB: begin
        reg_write = 1'b1;
        retired   = 1'b1;
        state_nx  = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a     = SRC_A_REG;
        alu_src_b     = SRC_B_REG;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
        retired       = 1'b1;
        state_nx      = ST_FETCH;
      end
`ifdef MC_ILLEGAL_TRAP_EN
      ST_TRAP: begin
        illegal_insn = 1'b1;
      end
`endif
      default: state_nx = ST_RESET;
    endcase
  end

  mc_retire_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (retired),
    .count(instr_count)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected output
// vectors are queued by stimulus and compared by a negedge monitor.
module tb_multicycle_control;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [6:0]       opcode;
  logic             mem_ready;
  logic             pc_write, pc_write_cond, i_or_d, mem_read;
  logic             mem_write, ir_write, mem_to_reg, reg_write;
  logic             pc_source, retired, illegal_insn;
  logic [1:0]       alu_src_a, alu_src_b, alu_op;
  logic [CNT_W-1:0] instr_count;

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .mem_ready    (mem_ready),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .i_or_d       (i_or_d),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .ir_write     (ir_write),
    .mem_to_reg   (mem_to_reg),
    .reg_write    (reg_write),
    .pc_source    (pc_source),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .retired      (retired),
    .instr_count  (instr_count),
    .illegal_insn (illegal_insn)
  );

  always #5 clk = ~clk;

  typedef enum int {
    S_RST, S_F, S_D, S_MA, S_MR, S_MWB,
    S_MW, S_EX, S_AWB, S_BR, S_TR
  } step_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       pc_source;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       retired;
    logic       illegal_insn;
  } ovec_t;

  typedef struct {
    step_t            step;
    ovec_t            v;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             q[$];
  logic [CNT_W-1:0] exp_cnt;
  int               checks = 0;
  int               errors = 0;

  function automatic ovec_t exp_vec(step_t s, logic r);
    ovec_t v;
    v = '0;
    case (s)
      S_F: begin
        v.mem_read  = 1'b1;
        v.alu_src_b = 2'b01;
        v.ir_write  = r;
        v.pc_write  = r;
      end
      S_D: begin
        v.alu_src_a = 2'b01;
        v.alu_src_b = 2'b10;
      end
      S_MA: begin
        v.alu_src_a = 2'b10;
        v.alu_src_b = 2'b10;
      end
      S_MR: begin
        v.mem_read = 1'b1;
        v.i_or_d   = 1'b1;
      end
      S_MWB: begin
        v.reg_write  = 1'b1;
        v.mem_to_reg = 1'b1;
        v.retired    = 1'b1;
      end
      S_MW: begin
        v.mem_write = 1'b1;
        v.i_or_d    = 1'b1;
        v.retired   = r;
      end
      S_EX: begin
        v.alu_src_a = 2'b10;
        v.alu_op    = 2'b10;
      end
      S_AWB: begin
        v.reg_write = 1'b1;
        v.retired   = 1'b1;
      end
      S_BR: begin
        v.alu_src_a     = 2'b10;
        v.alu_op        = 2'b01;
        v.pc_write_cond = 1'b1;
        v.pc_source     = 1'b1;
        v.retired       = 1'b1;
      end
      S_TR: v.illegal_insn = 1'b1;
      default: ;
    endcase
    return v;
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t  e;
      ovec_t a;
      e = q.pop_front();
      a = '{pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
            ir_write, mem_to_reg, reg_write, pc_source, alu_src_a,
            alu_src_b, alu_op, retired, illegal_insn};
      checks++;
      if (a !== e.v || instr_count !== e.cnt) begin
        errors++;
        $display("FAIL %s @%0t: got out=%h cnt=%0d, expected out=%h cnt=%0d",
                 e.step.name(), $time, a, instr_count, e.v, e.cnt);
      end
    end
  end

  task automatic cyc(input step_t s, input logic r);
    exp_t e;
    mem_ready = r;
    e.step = s;
    e.v    = exp_vec(s, r);
    e.cnt  = exp_cnt;
    q.push_back(e);
    if (s == S_MWB || s == S_AWB || s == S_BR || (s == S_MW && r))
      exp_cnt = exp_cnt + 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    exp_cnt = '0;
    cyc(S_RST, 1'b1);
    cyc(S_RST, 1'b1);
    rst_n = 1'b1;
    cyc(S_RST, 1'b1);
    cyc(S_RST, 1'b1);
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    opcode    = 7'b0;
    exp_cnt   = '0;
    @(posedge clk);
    #1;
    do_reset();

    opcode = 7'b0000011;
    cyc(S_F, 1); cyc(S_D, 1); cyc(S_MA, 1); cyc(S_MR, 1); cyc(S_MWB, 1);

    opcode = 7'b0100011;
    cyc(S_F, 1); cyc(S_D, 1); cyc(S_MA, 1);
    cyc(S_MW, 0); cyc(S_MW, 0); cyc(S_MW, 0); cyc(S_MW, 1);

    opcode = 7'b0110011;
    cyc(S_F, 1); cyc(S_D, 1); cyc(S_EX, 1); cyc(S_AWB, 1);
    opcode = 7'b1100011;
    cyc(S_F, 1); cyc(S_D, 1); cyc(S_BR, 1);

    opcode = 7'b0110011;
    cyc(S_F, 0); cyc(S_F, 0); cyc(S_F, 1);
    cyc(S_D, 1); cyc(S_EX, 1); cyc(S_AWB, 1);

    opcode = 7'b1111111;
    cyc(S_F, 1); cyc(S_D, 1);
`ifdef MC_ILLEGAL_TRAP_EN
    cyc(S_TR, 1); cyc(S_TR, 0); cyc(S_TR, 1);
    do_reset();
`endif

    opcode = 7'b0000011;
    cyc(S_F, 1); cyc(S_D, 1); cyc(S_MA, 1); cyc(S_MR, 0); cyc(S_MR, 0);
    do_reset();

    opcode = 7'b1100011;
    for (int i = 0; i < 16; i++) begin
      cyc(S_F, 1); cyc(S_D, 1); cyc(S_BR, 1);
    end
    cyc(S_F, 0);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
